// File: rtl/rggb_pkg.sv
// ---------------------------------------------------------------------------
// rggb_pkg
// Shared types and helpers for the RGGB packer/serializer pair.
//   rggb_word_t : one 2x2 Bayer window in channel order {R, G1, G2, B}
//   pixel_t     : one raw 8-bit sensor pixel
//   ser_state_t : serializer buffer state
//   PAR_*       : window parity codes {row[0], col[0]}
//   bayer_select: maps (word, parity, window position) to the raw pixel
// ---------------------------------------------------------------------------
package rggb_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g1;
        logic [7:0] g2;
        logic [7:0] b;
    } rggb_word_t;

    typedef logic [7:0] pixel_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ser_state_t;

    // Window parity {row[0], col[0]}; named after the sensor colour found
    // at window position 1 for that parity.
    localparam logic [1:0] PAR_RG = 2'b00;
    localparam logic [1:0] PAR_GR = 2'b01;
    localparam logic [1:0] PAR_GB = 2'b10;
    localparam logic [1:0] PAR_BG = 2'b11;

    // Raw pixel at window position pos (0..3) for a window of parity par.
    function automatic pixel_t bayer_select(input rggb_word_t w,
                                            input logic [1:0]  par,
                                            input logic [1:0]  pos);
        pixel_t px;
        px = w.r;
        case (par)
            PAR_RG: begin
                case (pos)
                    2'd0:    px = w.r;
                    2'd1:    px = w.g1;
                    2'd2:    px = w.g2;
                    default: px = w.b;
                endcase
            end
            PAR_GR: begin
                case (pos)
                    2'd0:    px = w.g1;
                    2'd1:    px = w.r;
                    2'd2:    px = w.b;
                    default: px = w.g2;
                endcase
            end
            PAR_GB: begin
                case (pos)
                    2'd0:    px = w.g1;
                    2'd1:    px = w.b;
                    2'd2:    px = w.r;
                    default: px = w.g2;
                endcase
            end
            default: begin
                case (pos)
                    2'd0:    px = w.b;
                    2'd1:    px = w.g1;
                    2'd2:    px = w.g2;
                    default: px = w.r;
                endcase
            end
        endcase
        return px;
    endfunction

endpackage

// File: rtl/bayer_pos_counter.sv
// ---------------------------------------------------------------------------
// bayer_pos_counter
// Row/column position of the current 2x2 window inside a frame.
// Shared between the RGGB packer and serializer.
// Ports:
//   clk, n_rst      : clock, asynchronous active-low reset
//   frame_start_i   : zeroes both counters; beats a coincident retire
//   retire_i        : current window finished, advance one window
//   next_par_o      : parity {row[0], col[0]} the counters hold after this
//                     edge; a word accepted this cycle belongs to it
//   frame_done_o    : registered pulse after the last window of a frame
// ---------------------------------------------------------------------------
module bayer_pos_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    localparam int CW    = $clog2(WIDTH),
    localparam int RW    = $clog2(HEIGHT)
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       frame_start_i,
    input  logic       retire_i,
    output logic [1:0] next_par_o,
    output logic       frame_done_o
);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_q, done_d;

    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        done_d = 1'b0;
        if (frame_start_i) begin
            col_d = '0;
            row_d = '0;
        end else if (retire_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d  = '0;
                    done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q  <= '0;
            row_q  <= '0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            done_q <= done_d;
        end
    end

    assign next_par_o   = {row_d[0], col_d[0]};
    assign frame_done_o = done_q;

endmodule

// File: rtl/rggb_serializer.sv
// ---------------------------------------------------------------------------
// rggb_serializer
// Turns channel-ordered RGGB words back into raw Bayer pixel order: each
// accepted word {R, G1, G2, B} is emitted as four pixels in 2x2 window order,
// chosen by the window parity tracked internally.
// Ports:
//   clk, n_rst             : clock, asynchronous active-low reset
//   frame_start            : zeroes the window position counters
//   in_valid/in_ready      : word handshake, rggb_in = {R, G1, G2, B}
//   out_valid/out_ready    : pixel handshake
//   pixel_out, pixel_pos   : current raw pixel and its window position 0..3
//   frame_done             : pulse after the last pixel of a frame transfers
//   frame_count            : frames completed (only with RGGB_FRAME_CNT_EN)
// Build option: define RGGB_FRAME_CNT_EN to add the frame_count output.
// ---------------------------------------------------------------------------
module rggb_serializer
    import rggb_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        frame_start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rggb_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  pixel_out,
    output logic [1:0]  pixel_pos,
    output logic        frame_done
`ifdef RGGB_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    ser_state_t state_q, state_d;
    logic [1:0] pos_q, pos_d;
    rggb_word_t word_q, word_d;
    logic [1:0] par_q, par_d;
    pixel_t     pixel_q, pixel_d;

    logic       accept;
    logic       xfer;
    logic       retire;
    logic [1:0] next_par;

    // Ready when empty, or when the last pixel leaves this cycle so the next
    // word loads with no bubble.
    assign in_ready = (state_q == IDLE) || ((pos_q == 2'd3) && out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign retire   = xfer && (pos_q == 2'd3);

    bayer_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .frame_start_i (frame_start),
        .retire_i      (retire),
        .next_par_o    (next_par),
        .frame_done_o  (frame_done)
    );

    // State register. The word buffer is cleared on reset so pixel_out
    // reads zero until the first word arrives.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            pos_q   <= 2'd0;
            word_q  <= '0;
            par_q   <= 2'b00;
            pixel_q <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            word_q  <= word_d;
            par_q   <= par_d;
            pixel_q <= pixel_d;
        end
    end

    // Next state. A new word takes the parity the counters hold after this
    // edge, which already accounts for a coincident retire or frame_start.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        word_d  = word_q;
        par_d   = par_q;
        if (accept) begin
            state_d = EMIT;
            pos_d   = 2'd0;
            word_d  = rggb_in;
            par_d   = next_par;
        end else if (xfer) begin
            if (pos_q == 2'd3) begin
                state_d = IDLE;
            end else begin
                pos_d = pos_q + 2'd1;
            end
        end
    end

    // Outputs: the pixel register is loaded one edge ahead from the next
    // state, and holds while stalled or idle.
    always_comb begin
        pixel_d = pixel_q;
        if ((accept || xfer) && (state_d == EMIT)) begin
            pixel_d = bayer_select(word_d, par_d, pos_d);
        end
    end

    assign out_valid = (state_q == EMIT);
    assign pixel_out = pixel_q;
    assign pixel_pos = pos_q;

`ifdef RGGB_FRAME_CNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            frame_count_q <= '0;
        end else if (frame_done) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_rggb_serializer.sv
// ---------------------------------------------------------------------------
// tb_rggb_serializer
// Directed bench for rggb_serializer with a 4x2-window frame. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rggb_serializer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        frame_start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rggb_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  pixel_out;
    logic [1:0]  pixel_pos;
    logic        frame_done;
`ifdef RGGB_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    int errors = 0;
    int checks = 0;

    // Expected pixel streams (position 1..4, MSB first) per window parity.
    localparam logic [31:0] WORD   = 32'hA1B2C3D4;
    localparam logic [31:0] EXP_00 = 32'hA1B2C3D4;
    localparam logic [31:0] EXP_01 = 32'hB2A1D4C3;
    localparam logic [31:0] EXP_10 = 32'hB2D4A1C3;
    localparam logic [31:0] EXP_11 = 32'hD4B2C3A1;

    logic [31:0] exp_win [8];

    rggb_serializer #(
        .WIDTH  (4),
        .HEIGHT (2)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rggb_in     (rggb_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pixel_out   (pixel_out),
        .pixel_pos   (pixel_pos),
        .frame_done  (frame_done)
`ifdef RGGB_FRAME_CNT_EN
        ,
        .frame_count (frame_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame_start();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Presents one word and returns just after the edge that accepts it.
    task automatic send_word(input logic [31:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        rggb_in  = w;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("accept_wait", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Checks four pixels in consecutive cycles with out_ready high.
    task automatic expect_word(input string tag, input logic [31:0] exp_px);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_pixel"}, {24'd0, pixel_out}, {24'd0, exp_px[31 - 8*k -: 8]});
            check({tag, "_pos"},   {30'd0, pixel_pos}, k);
            check({tag, "_no_frame_done"}, {31'd0, frame_done}, 32'd0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        int done_cnt;
        int low_run;
        int max_low;

        exp_win = '{EXP_00, EXP_01, EXP_00, EXP_01, EXP_10, EXP_11, EXP_10, EXP_11};

        n_rst       = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        rggb_in     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",   {31'd0, in_ready},   32'd1);
        check("rst_out_valid",  {31'd0, out_valid},  32'd0);
        check("rst_pixel_out",  {24'd0, pixel_out},  32'h00);
        check("rst_pixel_pos",  {30'd0, pixel_pos},  32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        n_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_output", {31'd0, out_valid}, 32'd0);
        end

        // Parity 00 single word, latency N+1..N+4
        out_ready = 1'b1;
        pulse_frame_start();
        send_word(WORD);
        expect_word("par00", EXP_00);
        @(negedge clk);
        check("par00_drained", {31'd0, out_valid}, 32'd0);

        // Full 4x2 frame, eight back-to-back words covering all parities
        pulse_frame_start();
        sent     = 0;
        got      = 0;
        done_cnt = 0;
        low_run  = 0;
        max_low  = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            in_valid = (sent < 8);
            rggb_in  = WORD;
            @(negedge clk);
            if (out_valid && got < 32) begin
                check("frame_pixel", {24'd0, pixel_out},
                      {24'd0, exp_win[got / 4][31 - 8*(got % 4) -: 8]});
                check("frame_pos", {30'd0, pixel_pos}, got % 4);
                got++;
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_done_after_px32", got, 32);
            end
            if (in_valid && in_ready) sent++;
            if (!in_ready) low_run++;
            else low_run = 0;
            if (low_run > max_low) max_low = low_run;
            tick();
        end
        in_valid = 1'b0;
        check("frame_pixels_seen", got, 32);
        check("frame_words_sent", sent, 8);
        check("frame_done_count", done_cnt, 1);
        check("in_ready_gap_le3", {31'd0, (max_low <= 3)}, 32'd1);

        // Backpressure at position 3 (pos=2) for five cycles
        pulse_frame_start();
        send_word(WORD);
        @(negedge clk);
        check("bp_px0", {24'd0, pixel_out}, 32'hA1);
        tick();
        @(negedge clk);
        check("bp_px1", {24'd0, pixel_out}, 32'hB2);
        tick();
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_pixel",    {24'd0, pixel_out}, 32'hC3);
            check("bp_hold_pos",      {30'd0, pixel_pos}, 32'd2);
            check("bp_hold_valid",    {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready},  32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_px2", {24'd0, pixel_out}, 32'hC3);
        check("bp_px2_pos", {30'd0, pixel_pos}, 32'd2);
        tick();
        @(negedge clk);
        check("bp_px3", {24'd0, pixel_out}, 32'hD4);
        check("bp_px3_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        @(negedge clk);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // frame_start coincident with the last window retire of a frame
        pulse_frame_start();
        repeat (7) send_word(WORD);
        send_word(WORD);
        repeat (3) tick();
        frame_start = 1'b1;
        in_valid    = 1'b1;
        rggb_in     = WORD;
        @(negedge clk);
        check("fs_last_pos", {30'd0, pixel_pos}, 32'd3);
        check("fs_last_px",  {24'd0, pixel_out}, 32'hA1);
        check("fs_in_ready", {31'd0, in_ready},  32'd1);
        tick();
        frame_start = 1'b0;
        in_valid    = 1'b0;
        expect_word("fs_par00", EXP_00);
        send_word(WORD);
        expect_word("fs_then_par01", EXP_01);
        send_word(WORD);
        expect_word("fs_then_par00", EXP_00);

`ifdef RGGB_FRAME_CNT_EN
        check("frame_count_before_reset", {16'd0, frame_count}, 32'd1);
`endif

        // Reset mid-word at pos=1 of a parity-01 window
        send_word(WORD);
        @(negedge clk);
        check("mid_px0", {24'd0, pixel_out}, 32'hB2);
        tick();
        n_rst = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("async_rst_pixel",     {24'd0, pixel_out}, 32'h00);
`ifdef RGGB_FRAME_CNT_EN
        check("async_rst_frame_count", {16'd0, frame_count}, 32'd0);
`endif
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        tick();
        send_word(WORD);
        expect_word("post_rst_par00", EXP_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
